// File: rtl/state_machine_pkg.sv
// state_machine_pkg: state encoding shared by the cyclic sequencer
package state_machine_pkg;
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10} state_t;
  localparam state_t RST_STATE = S0;
endpackage

// File: rtl/state_machine.sv
// state_machine: free-running modulo-3 sequencer driving its state index on y
module state_machine
  import state_machine_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] y
);
  state_t state_q = RST_STATE;
  state_t state_d;
  // advance S0->S1->S2->S0; the unused 2'b11 falls through to S0 so the block self-recovers
  always_comb begin
    state_d = state_q == S0 ? S1 : state_q == S1 ? S2 : S0;
  end
  // state register; reset has priority over the transition
  always_ff @(posedge clk) begin
    state_q <= rst ? RST_STATE : state_d;
  end
  assign y = state_q;
endmodule

// File: tb/tb_state_machine.sv
// tb_state_machine: table-driven and hand-sequenced checks of the modulo-3 sequencer
module tb_state_machine;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] y;
  int         errors = 0;
  int         checks = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic [1:0] exp;
  } vec_t;
  vec_t tbl[9];

  state_machine dut (.clk(clk), .rst(rst), .y(y));

  always #5 clk = ~clk;

  // y must never carry X/Z at any time
  always @(y) begin
    checks++;
    if ($isunknown(y)) begin
      errors++;
      $display("FAIL y_known: got %b required no X/Z at %0t", y, $time);
    end
  end

  task automatic check(input string name, input logic [1:0] exp);
    checks++;
    if (y !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b at %0t", name, y, exp, $time);
    end
  endtask

  // drive rst at the falling edge, queue the expectation, compare 1 time unit after the rising edge
  task automatic step(input string name, input logic r, input logic [1:0] exp);
    @(negedge clk);
    rst = r;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(name, exp_q.pop_front());
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'b00};
    tbl[1] = '{1'b1, 2'b00};
    tbl[2] = '{1'b0, 2'b01};
    tbl[3] = '{1'b0, 2'b10};
    tbl[4] = '{1'b0, 2'b00};
    tbl[5] = '{1'b0, 2'b01};
    tbl[6] = '{1'b0, 2'b10};
    tbl[7] = '{1'b0, 2'b00};
    tbl[8] = '{1'b0, 2'b01};

    #1;
    check("powerup_init", 2'b00);
    @(posedge clk);
    #1;
    check("powerup_first_edge", 2'b01);

    for (int i = 0; i < 9; i++) step($sformatf("table[%0d]", i), tbl[i].rst, tbl[i].exp);

    @(negedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    check("rst_pulse_between_edges", 2'b01);
    exp_q.push_back(2'b10);
    @(posedge clk);
    #1;
    check("rst_pulse_no_effect", exp_q.pop_front());

    step("mid_reset_s2", 1'b1, 2'b00);
    step("mid_reset_restart", 1'b0, 2'b01);

    @(negedge clk);
    force dut.state_q = state_machine_pkg::state_t'(2'b11);
    #1;
    check("illegal_forced", 2'b11);
    release dut.state_q;
    #1;
    exp_q.push_back(2'b00);
    @(posedge clk);
    #1;
    check("illegal_recover", exp_q.pop_front());
    step("after_recover_s1", 1'b0, 2'b01);
    step("after_recover_s2", 1'b0, 2'b10);
    step("after_recover_s0", 1'b0, 2'b00);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
